// File: rtl/limbo_pkg.sv
// limbo_pkg: shared types and defaults for the limbo register and its claim engine.
// Holds result/state encodings and a saturating increment used by the optional counters.
package limbo_pkg;

    localparam int DEF_TAG_WIDTH = 16;
    localparam int DEF_TIP_WIDTH = 8;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        EXPIRED  = 2'd1,
        GHOST    = 2'd2,
        TIMEOUT  = 2'd3
    } claim_res_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PURGE,
        RESP
    } claim_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/claim_rsp_timer.sv
// claim_rsp_timer: response wait timer; cleared by load, counts while enabled,
// holds at LIMIT-1 and flags that terminal count.
module claim_rsp_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_terminal
);

    localparam int             CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  TERM = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && (r_count != TERM)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == TERM);

endmodule

// File: rtl/limbo_claim_engine.sv
// limbo_claim_engine: accepts a claim tag, looks it up in the limbo store, purges on a live hit
// and returns RELEASED/EXPIRED/GHOST/TIMEOUT. Define LIMBO_CLAIM_STATS_EN for result counters.
module limbo_claim_engine
    import limbo_pkg::*;
#(
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int TIP_WIDTH   = DEF_TIP_WIDTH,
    parameter int BASE_TIP    = 5,
    parameter int RSP_TIMEOUT = 16,
    parameter int MAX_RETRY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 claim_valid,
    output logic                 claim_ready,
    input  logic [TAG_WIDTH-1:0] claim_tag,
    output logic                 lk_req_valid,
    input  logic                 lk_req_ready,
    output logic [TAG_WIDTH-1:0] lk_req_tag,
    output logic                 lk_req_purge,
    input  logic                 lk_rsp_valid,
    input  logic                 lk_rsp_hit,
    input  logic                 lk_rsp_expired,
    output logic                 res_valid,
    input  logic                 res_ready,
    output claim_res_e           res_code,
    output logic [TAG_WIDTH-1:0] res_tag,
    output logic [TIP_WIDTH-1:0] res_refund
`ifdef LIMBO_CLAIM_STATS_EN
    ,
    output logic [15:0]          stat_ghost,
    output logic [15:0]          stat_expired,
    output logic [15:0]          stat_timeout
`endif
);

    localparam int                   RW          = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0]        RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [TIP_WIDTH-1:0] GHOST_TIP   = TIP_WIDTH'(BASE_TIP);

    claim_state_e         r_state;
    logic [TAG_WIDTH-1:0] r_tag;
    claim_res_e           r_code;
    logic [TIP_WIDTH-1:0] r_refund;
    logic [RW-1:0]        r_retry;
    logic                 r_claim_ready;
    logic                 r_lk_req_valid;
    logic                 r_lk_req_purge;
    logic                 r_res_valid;

    claim_state_e         w_next_state;
    claim_res_e           w_next_code;
    logic [TIP_WIDTH-1:0] w_next_refund;
    logic [RW-1:0]        w_next_retry;
    logic                 w_latch_tag;
    logic                 w_timer_load;
    logic                 w_timer_en;
    logic                 w_timer_term;

    claim_rsp_timer #(
        .LIMIT(RSP_TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_en       (w_timer_en),
        .o_terminal (w_timer_term)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_code   = r_code;
        w_next_refund = r_refund;
        w_next_retry  = r_retry;
        w_latch_tag   = 1'b0;
        w_timer_load  = 1'b0;
        w_timer_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (claim_valid) begin
                    w_next_state = REQ;
                    w_latch_tag  = 1'b1;
                    w_next_retry = '0;
                end
            end
            REQ: begin
                if (lk_req_ready) begin
                    w_next_state = WAIT;
                    w_timer_load = 1'b1;
                end
            end
            WAIT: begin
                w_timer_en = 1'b1;
                // A response arriving on the terminal cycle takes priority over the timeout.
                if (lk_rsp_valid) begin
                    if (!lk_rsp_hit) begin
                        w_next_state  = RESP;
                        w_next_code   = GHOST;
                        w_next_refund = GHOST_TIP;
                    end else if (lk_rsp_expired) begin
                        w_next_state  = RESP;
                        w_next_code   = EXPIRED;
                        w_next_refund = '0;
                    end else begin
                        w_next_state = PURGE;
                    end
                end else if (w_timer_term) begin
                    if (r_retry < RETRY_LIMIT) begin
                        w_next_retry = r_retry + 1'b1;
                        w_next_state = REQ;
                    end else begin
                        w_next_state  = RESP;
                        w_next_code   = TIMEOUT;
                        w_next_refund = '0;
                    end
                end
            end
            PURGE: begin
                if (lk_req_ready) begin
                    w_next_state  = RESP;
                    w_next_code   = RELEASED;
                    w_next_refund = '0;
                end
            end
            RESP: begin
                if (res_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they change only on the clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_tag          <= '0;
            r_code         <= RELEASED;
            r_refund       <= '0;
            r_retry        <= '0;
            r_claim_ready  <= 1'b1;
            r_lk_req_valid <= 1'b0;
            r_lk_req_purge <= 1'b0;
            r_res_valid    <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_code         <= w_next_code;
            r_refund       <= w_next_refund;
            r_retry        <= w_next_retry;
            r_claim_ready  <= (w_next_state == IDLE);
            r_lk_req_valid <= (w_next_state == REQ) || (w_next_state == PURGE);
            r_lk_req_purge <= (w_next_state == PURGE);
            r_res_valid    <= (w_next_state == RESP);
            if (w_latch_tag) begin
                r_tag <= claim_tag;
            end
        end
    end

    assign claim_ready  = r_claim_ready;
    assign lk_req_valid = r_lk_req_valid;
    assign lk_req_purge = r_lk_req_purge;
    assign lk_req_tag   = r_tag;
    assign res_valid    = r_res_valid;
    assign res_code     = r_code;
    assign res_tag      = r_tag;
    assign res_refund   = r_refund;

`ifdef LIMBO_CLAIM_STATS_EN
    logic        w_resp_entry;
    logic [15:0] r_stat_ghost;
    logic [15:0] r_stat_expired;
    logic [15:0] r_stat_timeout;

    assign w_resp_entry = (w_next_state == RESP) && (r_state != RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_ghost   <= '0;
            r_stat_expired <= '0;
            r_stat_timeout <= '0;
        end else if (w_resp_entry) begin
            case (w_next_code)
                GHOST:   r_stat_ghost   <= sat_inc16(r_stat_ghost);
                EXPIRED: r_stat_expired <= sat_inc16(r_stat_expired);
                TIMEOUT: r_stat_timeout <= sat_inc16(r_stat_timeout);
                default: ;
            endcase
        end
    end

    assign stat_ghost   = r_stat_ghost;
    assign stat_expired = r_stat_expired;
    assign stat_timeout = r_stat_timeout;
`endif

endmodule

// File: tb/tb_limbo_claim_engine.sv
// tb_limbo_claim_engine: directed and randomized claims against a transaction-level model
// of the claim engine; honours LIMBO_CLAIM_STATS_EN for the result counters.
`timescale 1ns/1ps
module tb_limbo_claim_engine;
    import limbo_pkg::*;

    localparam int TW          = 16;
    localparam int PW          = 8;
    localparam int BASE_TIP    = 5;
    localparam int RSP_TIMEOUT = 16;
    localparam int MAX_RETRY   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          claim_valid = 1'b0;
    logic          claim_ready;
    logic [TW-1:0] claim_tag = '0;
    logic          lk_req_valid;
    logic          lk_req_ready = 1'b0;
    logic [TW-1:0] lk_req_tag;
    logic          lk_req_purge;
    logic          lk_rsp_valid = 1'b0;
    logic          lk_rsp_hit = 1'b0;
    logic          lk_rsp_expired = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [1:0]    res_code;
    logic [TW-1:0] res_tag;
    logic [PW-1:0] res_refund;
`ifdef LIMBO_CLAIM_STATS_EN
    logic [15:0]   stat_ghost, stat_expired, stat_timeout;
`endif

    limbo_claim_engine #(
        .TAG_WIDTH(TW), .TIP_WIDTH(PW), .BASE_TIP(BASE_TIP),
        .RSP_TIMEOUT(RSP_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst),
        .claim_valid(claim_valid), .claim_ready(claim_ready), .claim_tag(claim_tag),
        .lk_req_valid(lk_req_valid), .lk_req_ready(lk_req_ready),
        .lk_req_tag(lk_req_tag), .lk_req_purge(lk_req_purge),
        .lk_rsp_valid(lk_rsp_valid), .lk_rsp_hit(lk_rsp_hit), .lk_rsp_expired(lk_rsp_expired),
        .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
        .res_tag(res_tag), .res_refund(res_refund)
`ifdef LIMBO_CLAIM_STATS_EN
        , .stat_ghost(stat_ghost), .stat_expired(stat_expired), .stat_timeout(stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: what the engine owes the outside world right now.
    bit          m_busy, m_need_lookup, m_need_purge, m_waiting, m_have_res;
    int          m_wait_cnt, m_tries, m_code, m_refund;
    logic [15:0] m_tag;
    int          m_stat_g, m_stat_e, m_stat_t;

    // Observed handshakes, used by the directed literal checks.
    int          cyc, idle_run, obs_lookups, obs_purges, obs_last_gap, obs_claim_cyc, obs_lat;
    int          obs_res_code, obs_res_refund, obs_res_tag, obs_purge_tag;
    bit          obs_prev_res;

    task automatic model_result(input int code, input int refund);
        m_have_res = 1'b1;
        m_code     = code;
        m_refund   = refund;
        if (code == 2 && m_stat_g < 65535) m_stat_g++;
        if (code == 1 && m_stat_e < 65535) m_stat_e++;
        if (code == 3 && m_stat_t < 65535) m_stat_t++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0; m_need_lookup = 0; m_need_purge = 0; m_waiting = 0; m_have_res = 0;
            m_stat_g = 0; m_stat_e = 0; m_stat_t = 0;
            obs_prev_res = 0;
            check("rst_claim_ready", 32'(claim_ready), 1);
            check("rst_lk_req_valid", 32'(lk_req_valid), 0);
            check("rst_lk_req_purge", 32'(lk_req_purge), 0);
            check("rst_res_valid", 32'(res_valid), 0);
            check("rst_res_code", 32'(res_code), 0);
            check("rst_res_refund", 32'(res_refund), 0);
        end else begin
            cyc++;
            check("claim_ready", 32'(claim_ready), 32'(!m_busy));
            check("lk_req_valid", 32'(lk_req_valid), 32'(m_need_lookup || m_need_purge));
            if (m_need_lookup || m_need_purge) begin
                check("lk_req_tag", 32'(lk_req_tag), 32'(m_tag));
                check("lk_req_purge", 32'(lk_req_purge), 32'(m_need_purge));
            end
            check("res_valid", 32'(res_valid), 32'(m_have_res));
            if (m_have_res) begin
                check("res_code", 32'(res_code), m_code);
                check("res_tag", 32'(res_tag), 32'(m_tag));
                check("res_refund", 32'(res_refund), m_refund);
            end
`ifdef LIMBO_CLAIM_STATS_EN
            check("stat_ghost", 32'(stat_ghost), m_stat_g);
            check("stat_expired", 32'(stat_expired), m_stat_e);
            check("stat_timeout", 32'(stat_timeout), m_stat_t);
`endif
            if (lk_req_valid && lk_req_ready) begin
                if (lk_req_purge) begin
                    obs_purges++;
                    obs_purge_tag = 32'(lk_req_tag);
                end else begin
                    obs_lookups++;
                    obs_last_gap = idle_run;
                end
                idle_run = 0;
            end else if (!lk_req_valid) begin
                idle_run++;
            end
            if (claim_valid && claim_ready) obs_claim_cyc = cyc;
            if (res_valid && !obs_prev_res) obs_lat = cyc - obs_claim_cyc;
            obs_prev_res = res_valid;
            if (res_valid && res_ready) begin
                obs_res_code   = 32'(res_code);
                obs_res_refund = 32'(res_refund);
                obs_res_tag    = 32'(res_tag);
            end

            if (!m_busy) begin
                if (claim_valid) begin
                    m_busy = 1; m_tag = claim_tag; m_need_lookup = 1; m_tries = 0;
                end
            end else if (m_need_lookup) begin
                if (lk_req_ready) begin
                    m_need_lookup = 0; m_waiting = 1; m_wait_cnt = 0; m_tries++;
                end
            end else if (m_waiting) begin
                if (lk_rsp_valid) begin
                    m_waiting = 0;
                    if (!lk_rsp_hit)         model_result(2, BASE_TIP);
                    else if (lk_rsp_expired) model_result(1, 0);
                    else                     m_need_purge = 1;
                end else if (m_wait_cnt == RSP_TIMEOUT - 1) begin
                    m_waiting = 0;
                    if (m_tries <= MAX_RETRY) m_need_lookup = 1;
                    else                      model_result(3, 0);
                end else begin
                    m_wait_cnt++;
                end
            end else if (m_need_purge) begin
                if (lk_req_ready) begin
                    m_need_purge = 0;
                    model_result(0, 0);
                end
            end else if (m_have_res) begin
                if (res_ready) begin
                    m_have_res = 0; m_busy = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_high(input string name, input int which);
        int k = 0;
        logic s;
        s = (which == 0) ? claim_ready : (which == 1) ? lk_req_valid : res_valid;
        while (!s && k < 200) begin
            step();
            k++;
            s = (which == 0) ? claim_ready : (which == 1) ? lk_req_valid : res_valid;
        end
        if (!s) check(name, 32'(s), 1);
    endtask

    task automatic claim(input logic [15:0] tag);
        wait_high("wait_claim_ready", 0);
        claim_valid = 1'b1;
        claim_tag   = tag;
        step();
        claim_valid = 1'b0;
        claim_tag   = 16'($urandom);
    endtask

    // Serves one lookup or purge request; stray responses during the hold are ignored by design.
    task automatic serve_req(input int delay);
        wait_high("wait_lk_req_valid", 1);
        repeat (delay) begin
            lk_rsp_valid = 1'($urandom_range(0, 1));
            lk_rsp_hit   = 1'($urandom_range(0, 1));
            step();
        end
        lk_rsp_valid = 1'b0;
        lk_req_ready = 1'b1;
        step();
        lk_req_ready = 1'b0;
    endtask

    task automatic respond(input int delay, input bit hit, input bit exp);
        repeat (delay) step();
        lk_rsp_valid   = 1'b1;
        lk_rsp_hit     = hit;
        lk_rsp_expired = exp;
        step();
        lk_rsp_valid   = 1'b0;
        lk_rsp_hit     = 1'b0;
        lk_rsp_expired = 1'b0;
    endtask

    task automatic take_result(input int delay);
        wait_high("wait_res_valid", 2);
        repeat (delay) step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    // n_to = lookups that get no answer before the answering one (> MAX_RETRY means never).
    task automatic run_claim(input logic [15:0] tag, input int n_to, input int dly,
                             input bit hit, input bit exp, input int qd, input int rd);
        bit answered = 0;
        claim(tag);
        for (int a = 0; a <= MAX_RETRY && !answered; a++) begin
            serve_req(qd);
            if (a == n_to) begin
                respond(dly, hit, exp);
                answered = 1;
            end
        end
        if (answered && hit && !exp) serve_req(qd);
        take_result(rd);
    endtask

    int p0, l0;

    initial begin
        repeat (3) step();
        rst = 1'b1;
        step();

        p0 = obs_purges;
        run_claim(16'h1234, 0, 0, 1, 0, 0, 0);
        check("t1_purges", obs_purges - p0, 1);
        check("t1_purge_tag", obs_purge_tag, 32'h1234);
        check("t1_code", obs_res_code, 0);
        check("t1_refund", obs_res_refund, 0);
        check("t1_latency", obs_lat, 4);

        p0 = obs_purges;
        run_claim(16'h00AA, 0, 0, 0, 0, 0, 0);
        check("t2_purges", obs_purges - p0, 0);
        check("t2_code", obs_res_code, 2);
        check("t2_refund", obs_res_refund, 5);
        check("t2_tag", obs_res_tag, 32'h00AA);
        check("t2_latency", obs_lat, 3);

        p0 = obs_purges;
        run_claim(16'hBEEF, 0, 2, 1, 1, 1, 2);
        check("t3_purges", obs_purges - p0, 0);
        check("t3_code", obs_res_code, 1);
        check("t3_refund", obs_res_refund, 0);

        l0 = obs_lookups;
        run_claim(16'h0C0D, MAX_RETRY + 1, 0, 0, 0, 0, 0);
        check("t4_lookups", obs_lookups - l0, 3);
        check("t4_gap", obs_last_gap, 16);
        check("t4_code", obs_res_code, 3);
        check("t4_refund", obs_res_refund, 0);

        p0 = obs_purges;
        run_claim(16'h5A5A, 0, RSP_TIMEOUT - 1, 1, 0, 5, 5);
        check("t5_purges", obs_purges - p0, 1);
        check("t5_code", obs_res_code, 0);
        check("t5_tag", obs_res_tag, 32'h5A5A);

        claim(16'h7777);
        serve_req(0);
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        check("t6_claim_ready", 32'(claim_ready), 1);
        check("t6_res_valid", 32'(res_valid), 0);
        check("t6_lk_req_valid", 32'(lk_req_valid), 0);
`ifdef LIMBO_CLAIM_STATS_EN
        check("t6_stat_ghost_clr", 32'(stat_ghost), 0);
`endif
        step();
        step();
        rst = 1'b1;
        p0 = obs_purges;
        respond(0, 1, 0);
        repeat (4) step();
        check("t6_no_result", 32'(res_valid), 0);
        check("t6_no_purge", obs_purges - p0, 0);
        run_claim(16'h0F0F, 0, 1, 0, 0, 0, 0);
        check("t6_ghost_code", obs_res_code, 2);
`ifdef LIMBO_CLAIM_STATS_EN
        check("t6_stat_ghost", 32'(stat_ghost), 1);
`endif

        for (int i = 0; i < 40; i++) begin
            run_claim(16'($urandom), int'($urandom_range(0, MAX_RETRY + 1)),
                      int'($urandom_range(0, RSP_TIMEOUT - 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
